rb_line_buffer_ctrl: RTL and testbench

- Controller for the asymmetric row-buffer BRAM: 8-bit pixel write port A, 32-bit four-pixel read port B.
- Accepts a raster pixel stream and writes each pixel into a circular set of row slots.
- Once KERNEL_ROWS complete rows are held, it sequences port-B reads to emit one vertical window pass: for each 32-bit column word, one word per kernel row, oldest row first.
- Sits between the pixel source and the neighbourhood-processing kernel, and owns all BRAM enables and addresses.

---
 rtl/rb_pkg.sv | 31 +++
 rtl/rb_skid_fifo.sv | 60 ++++++
 rtl/rb_line_buffer_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rb_line_buffer_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rb_pkg.sv
// Shared types and sizing helpers for the row-buffer controller.
package rb_pkg;

  localparam int PIX_W        = 8;
  localparam int WORD_W       = 32;
  localparam int PIX_PER_WORD = WORD_W / PIX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rb_state_e;

  function automatic int words_per_row(input int img_width);
    return img_width / PIX_PER_WORD;
  endfunction

  function automatic int addr_w_a(input int depth);
    return $clog2(depth / PIX_W);
  endfunction

  function automatic int addr_w_b(input int depth);
    return $clog2(depth / WORD_W);
  endfunction

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rb_skid_fifo.sv
// Two-entry FIFO that absorbs BRAM read returns while the kernel stalls.
module rb_skid_fifo #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    do_pop   = pop && (cnt_q != 2'd0);
    do_push  = push && ((cnt_q != 2'd2) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    if (flush) begin
      cnt_d    = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid = (cnt_q != 2'd0);
  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/rb_line_buffer_ctrl.sv
// Row-buffer BRAM controller: raster pixel writes on port A, vertical window reads on port B.
// state | meaning
// IDLE  | waiting for KERNEL_ROWS complete rows
// RUN   | issuing window reads, word-major, oldest row first
// DRAIN | all reads issued, waiting for the last word to be accepted
module rb_line_buffer_ctrl
  import rb_pkg::*;
#(
  parameter int IMG_WIDTH   = 64,
  parameter int ROW_SLOTS   = 4,
  parameter int KERNEL_ROWS = 3,
  parameter int DEPTH       = 16384,
  parameter int AW_A        = addr_w_a(DEPTH),
  parameter int AW_B        = addr_w_b(DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               frame_sync,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [PIX_W-1:0]                   s_data,
  output logic                               EN_A,
  output logic [AW_A-1:0]                    ADDR_A,
  output logic [PIX_W-1:0]                   DIN_A,
  output logic                               EN_B,
  output logic [AW_B-1:0]                    ADDR_B,
  input  logic [WORD_W-1:0]                  DOUT_B,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [WORD_W-1:0]                  m_data,
  output logic [$clog2(KERNEL_ROWS)-1:0]     m_row,
  output logic                               m_last,
  output logic [$clog2(ROW_SLOTS+1)-1:0]     rows_stored,
  output logic                               busy
);

  localparam int WPR    = words_per_row(IMG_WIDTH);
  localparam int COL_W  = clog2_min1(IMG_WIDTH);
  localparam int SLOT_W = clog2_min1(ROW_SLOTS);
  localparam int WRD_W  = clog2_min1(WPR);
  localparam int ROW_W  = $clog2(KERNEL_ROWS);
  localparam int RS_W   = $clog2(ROW_SLOTS + 1);
  localparam int TAG_W  = ROW_W + 1;

  rb_state_e          state_q, state_d;
  logic [COL_W-1:0]   wr_col_q, wr_col_d;
  logic [SLOT_W-1:0]  wr_slot_q, wr_slot_d;
  logic [SLOT_W-1:0]  rd_base_q, rd_base_d;
  logic [RS_W-1:0]    rows_q, rows_d;
  logic [WRD_W-1:0]   w_q, w_d;
  logic [ROW_W-1:0]   k_q, k_d;
  logic               inflight_q, inflight_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic                    row_done, release_pass, pop, issue, last_issue;
  logic                    fifo_valid, fifo_push;
  logic [1:0]              fifo_count;
  logic [WORD_W+TAG_W-1:0] fifo_head;
  int                      rd_slot;

  rb_skid_fifo #(.W(WORD_W + TAG_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (frame_sync),
    .push      (fifo_push),
    .push_data ({DOUT_B, tag_q}),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign m_valid     = fifo_valid;
  assign m_data      = fifo_head[WORD_W+TAG_W-1:TAG_W];
  assign m_row       = fifo_head[TAG_W-1:1];
  assign m_last      = fifo_valid & fifo_head[0];
  assign rows_stored = rows_q;
  assign busy        = (state_q != IDLE);
  assign pop         = m_valid & m_ready;
  assign fifo_push   = inflight_q & ~frame_sync;

  always_comb begin
    s_ready  = (rows_q < RS_W'(ROW_SLOTS));
    EN_A     = s_valid & s_ready & ~frame_sync;
    ADDR_A   = AW_A'(int'(wr_slot_q) * IMG_WIDTH + int'(wr_col_q));
    DIN_A    = s_data;
    row_done = EN_A && (wr_col_q == COL_W'(IMG_WIDTH - 1));
    release_pass = pop & m_last & (state_q == DRAIN) & ~frame_sync;

    last_issue = (w_q == WRD_W'(WPR - 1)) && (k_q == ROW_W'(KERNEL_ROWS - 1));
    // A pop this cycle frees a slot, which is what sustains one word per cycle.
    issue = (state_q == RUN) && !frame_sync &&
            ((3'(fifo_count) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
    rd_slot = int'(rd_base_q) + int'(k_q);
    if (rd_slot >= ROW_SLOTS) rd_slot = rd_slot - ROW_SLOTS;
    ADDR_B = AW_B'(rd_slot * WPR + int'(w_q));
    EN_B   = issue;

    state_d    = state_q;
    wr_col_d   = wr_col_q;
    wr_slot_d  = wr_slot_q;
    rd_base_d  = rd_base_q;
    w_d        = w_q;
    k_d        = k_q;
    inflight_d = issue;
    tag_d      = {k_q, last_issue};
    rows_d     = rows_q + RS_W'(row_done) - RS_W'(release_pass);

    if (EN_A) begin
      wr_col_d = row_done ? '0 : wr_col_q + 1'b1;
      if (row_done)
        wr_slot_d = (wr_slot_q == SLOT_W'(ROW_SLOTS - 1)) ? '0 : wr_slot_q + 1'b1;
    end

    case (state_q)
      IDLE: if (rows_q >= RS_W'(KERNEL_ROWS)) begin
        state_d = RUN;
        w_d     = '0;
        k_d     = '0;
      end
      RUN: if (issue) begin
        if (last_issue) begin
          state_d = DRAIN;
          w_d     = '0;
          k_d     = '0;
        end else if (k_q == ROW_W'(KERNEL_ROWS - 1)) begin
          k_d = '0;
          w_d = w_q + 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: if (release_pass) begin
        state_d   = IDLE;
        rd_base_d = (rd_base_q == SLOT_W'(ROW_SLOTS - 1)) ? '0 : rd_base_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (frame_sync) begin
      state_d    = IDLE;
      wr_col_d   = '0;
      wr_slot_d  = '0;
      rd_base_d  = '0;
      rows_d     = '0;
      w_d        = '0;
      k_d        = '0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_col_q   <= '0;
      wr_slot_q  <= '0;
      rd_base_q  <= '0;
      rows_q     <= '0;
      w_q        <= '0;
      k_q        <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_col_q   <= wr_col_d;
      wr_slot_q  <= wr_slot_d;
      rd_base_q  <= rd_base_d;
      rows_q     <= rows_d;
      w_q        <= w_d;
      k_q        <= k_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

endmodule

// File: tb/tb_rb_line_buffer_ctrl.sv
// Scoreboard bench for rb_line_buffer_ctrl with a BRAM model and a row-queue reference model.
module tb_rb_line_buffer_ctrl;

  localparam int W         = 8;
  localparam int ROW_SLOTS = 4;
  localparam int KR        = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_sync = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        EN_A;
  logic [10:0] ADDR_A;
  logic [7:0]  DIN_A;
  logic        EN_B;
  logic [8:0]  ADDR_B;
  logic [31:0] DOUT_B;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [1:0]  m_row;
  logic        m_last;
  logic [2:0]  rows_stored;
  logic        busy;

  rb_line_buffer_ctrl #(
    .IMG_WIDTH(W), .ROW_SLOTS(ROW_SLOTS), .KERNEL_ROWS(KR), .DEPTH(16384)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_sync(frame_sync),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .EN_A(EN_A), .ADDR_A(ADDR_A), .DIN_A(DIN_A),
    .EN_B(EN_B), .ADDR_B(ADDR_B), .DOUT_B(DOUT_B),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
    .m_last(m_last), .rows_stored(rows_stored), .busy(busy)
  );

  always #5 clk = ~clk;

  // Byte-addressed BRAM, port B returns four bytes little-endian one cycle later.
  logic [7:0] bram [0:2047];
  always @(posedge clk) begin
    if (EN_A) bram[ADDR_A] <= DIN_A;
    if (EN_B) DOUT_B <= {bram[{ADDR_B, 2'd3}], bram[{ADDR_B, 2'd2}],
                         bram[{ADDR_B, 2'd1}], bram[{ADDR_B, 2'd0}]};
  end

  typedef struct { logic [8*W-1:0] pix; int slot; } row_t;
  typedef struct { logic [31:0] data; int k; logic last; } word_t;

  row_t          rows_m[$];
  word_t         exp_w[$];
  int            exp_a[$];
  logic [8*W-1:0] cur_row;
  int            pix_cnt, outstanding, last_cnt, enb_cnt, next_row;
  bit            pass_active, rand_ready;
  int            checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic void model_clear();
    rows_m.delete();
    exp_w.delete();
    exp_a.delete();
    cur_row     = '0;
    pix_cnt     = 0;
    outstanding = 0;
    pass_active = 0;
  endfunction

  // A pass covers the oldest KR held rows, column-word major, oldest row first.
  function automatic void schedule_pass();
    for (int w = 0; w < W / 4; w++)
      for (int k = 0; k < KR; k++) begin
        exp_w.push_back('{data: rows_m[k].pix[w*32 +: 32], k: k,
                          last: (w == W / 4 - 1) && (k == KR - 1)});
        exp_a.push_back(rows_m[k].slot * (W / 4) + w);
      end
    pass_active = 1;
  endfunction

  // Monitor: at each negedge observe the transfers that the next posedge commits.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("rows_stored", rows_stored, rows_m.size());
        chk("s_ready", s_ready, rows_m.size() < ROW_SLOTS);
        if (frame_sync) begin
          chk("en_a_during_sync", EN_A, 0);
          model_clear();
        end else begin
          chk("en_a", EN_A, s_valid && (rows_m.size() < ROW_SLOTS));
          if (m_valid) begin
            if (exp_w.size() == 0) fail("unexpected_m_valid");
            else begin
              chk("m_data", m_data, exp_w[0].data);
              chk("m_row", m_row, exp_w[0].k);
              chk("m_last", m_last, exp_w[0].last);
              if (m_ready) begin
                outstanding--;
                last_cnt += exp_w[0].last ? 1 : 0;
                if (exp_w[0].last) begin
                  void'(rows_m.pop_front());
                  pass_active = 0;
                end
                void'(exp_w.pop_front());
              end
            end
          end
          if (EN_B) begin
            enb_cnt++;
            if (exp_a.size() == 0) fail("unexpected_en_b");
            else chk("addr_b", ADDR_B, exp_a.pop_front());
            outstanding++;
            chk("outstanding_le_2", outstanding <= 2, 1);
          end
          if (EN_A) begin
            chk("addr_a", ADDR_A, ((pix_cnt / W) % ROW_SLOTS) * W + pix_cnt % W);
            chk("din_a", DIN_A, s_data);
            cur_row[(pix_cnt % W)*8 +: 8] = s_data;
            if (pix_cnt % W == W - 1)
              rows_m.push_back('{pix: cur_row, slot: (pix_cnt / W) % ROW_SLOTS});
            pix_cnt++;
          end
          if (!pass_active && rows_m.size() >= KR) schedule_pass();
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_rows(input int n, input bit gaps);
    bit acc;
    int t;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gaps) begin
          s_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        s_valid = 1'b1;
        s_data  = 8'(next_row * 16 + c);
        t = 0;
        do begin
          @(negedge clk);
          acc = s_ready;
          @(posedge clk);
          #1;
          t++;
        end while (!acc && t < 300);
        if (!acc) fail("pixel_accept_timeout");
      end
      next_row++;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    while (pass_active || busy) begin
      if (t == bound) begin
        fail("wait_idle_timeout");
        break;
      end
      @(posedge clk);
      #2;
      t++;
    end
  endtask

  task automatic pulse_sync();
    @(posedge clk);
    #1;
    frame_sync = 1'b1;
    s_valid    = 1'b0;
    @(posedge clk);
    #1;
    frame_sync = 1'b0;
    next_row   = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    last_cnt = 0;
    enb_cnt  = 0;
    next_row = 0;
    rand_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_en_b", EN_B, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_rows_stored", rows_stored, 0);
    chk("rst_s_ready", s_ready, 1);

    // Fill: first pass over rows 0..2.
    m_ready = 1'b1;
    send_rows(3, 0);
    wait_idle(200);
    chk("fill_rows_after_pass", rows_stored, 2);

    // Backpressure mid-pass over rows 1..3.
    send_rows(1, 0);
    repeat (3) @(posedge clk);
    #1 m_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stall_m_valid_held", m_valid, 1);
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_idle(200);

    // Full ring.
    pulse_sync();
    m_ready = 1'b0;
    send_rows(4, 0);
    #1;
    chk("full_s_ready", s_ready, 0);
    chk("full_rows_stored", rows_stored, 4);
    m_ready = 1'b1;
    wait_idle(300);
    chk("full_s_ready_restored", s_ready, 1);
    chk("full_rows_final", rows_stored, 2);

    // Wrap: six rows streamed continuously gives four passes.
    pulse_sync();
    m_ready  = 1'b1;
    last_cnt = 0;
    send_rows(6, 0);
    wait_idle(300);
    chk("wrap_pass_count", last_cnt, 4);
    chk("wrap_rows_final", rows_stored, 2);

    // frame_sync in the middle of a stalled pass, with a pixel offered.
    pulse_sync();
    m_ready = 1'b0;
    send_rows(3, 0);
    repeat (4) @(posedge clk);
    #1;
    frame_sync = 1'b1;
    s_valid    = 1'b1;
    s_data     = 8'hAA;
    @(posedge clk);
    #1;
    frame_sync = 1'b0;
    s_valid    = 1'b0;
    next_row   = 0;
    #1;
    chk("sync_m_valid", m_valid, 0);
    chk("sync_rows_stored", rows_stored, 0);
    chk("sync_busy", busy, 0);
    m_ready = 1'b1;
    send_rows(1, 0);
    pulse_sync();

    // Asynchronous reset during RUN.
    m_ready = 1'b0;
    send_rows(3, 0);
    repeat (4) @(posedge clk);
    #2;
    chk("pre_reset_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("areset_m_valid", m_valid, 0);
    chk("areset_en_b", EN_B, 0);
    chk("areset_busy", busy, 0);
    chk("areset_m_last", m_last, 0);
    chk("areset_rows_stored", rows_stored, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    next_row = 0;
    enb_cnt  = 0;
    m_ready  = 1'b1;
    send_rows(2, 0);
    repeat (6) @(posedge clk);
    #2;
    chk("no_en_b_before_3_rows", enb_cnt, 0);
    send_rows(1, 0);
    wait_idle(200);
    chk("en_b_after_3_rows", enb_cnt, 3 * W / 4);

    // Randomised traffic: input gaps and random m_ready.
    pulse_sync();
    rand_ready = 1;
    send_rows(10, 1);
    rand_ready = 0;
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_idle(500);
    chk("rand_rows_final", rows_stored, 2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
